ducddc_setting_sched: RTL and testbench

- Settings-bus scheduler for one DUC/DDC chain.
- Arbitrates register-write bursts from NUM_REQ requesters (host shim, timed-command engine, auto-retune logic) onto the single set_stb/set_addr/set_data bus that feeds axi_rate_change, duc and ddc.
- Keeps each burst atomic and enforces a minimum strobe spacing.
- After any burst that touches a rate register, issues a timed clear pulse so filter state is flushed before the next burst.

---
 rtl/ducddc_setting_sched.sv | 212 +++++++++++++++++++++
 tb/tb_ducddc_setting_sched.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ducddc_setting_sched.sv
// Settings-bus scheduler for one DUC/DDC chain: round-robin arbitration of atomic write
// bursts onto set_stb/set_addr/set_data, strobe spacing, and a flush pulse after rate writes.
module ducddc_setting_sched #(
  parameter int unsigned  NUM_REQ       = 3,
  parameter int unsigned  STB_GAP       = 1,
  parameter int unsigned  CLEAR_CYCLES  = 4,
  parameter int unsigned  TIMEOUT       = 64,
  parameter logic [255:0] RATE_ADDR_MAP = (256'd1 << 128) | (256'd1 << 129) |
                                          (256'd1 << 131) | (256'd1 << 143)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ*40-1:0]      req_tdata,
  input  logic [NUM_REQ-1:0]         req_tlast,
  input  logic [NUM_REQ-1:0]         req_tvalid,
  output logic [NUM_REQ-1:0]         req_tready,
  output logic                       set_stb,
  output logic [7:0]                 set_addr,
  output logic [31:0]                set_data,
  output logic                       clear_user,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       err_timeout
);

  localparam int unsigned IdW    = $clog2(NUM_REQ);
  localparam int unsigned StallW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StWrite, StClear} state_e;

  state_e              state_q, state_d;
  logic [IdW-1:0]      grant_q, grant_d;
  logic [IdW-1:0]      rr_q, rr_d;
  logic [3:0]          gap_q, gap_d;
  logic [7:0]          clr_cnt_q, clr_cnt_d;
  logic [StallW-1:0]   stall_q, stall_d;
  logic                rate_hit_q, rate_hit_d;
  logic                clr_pend_q, clr_pend_d;
  logic                stb_q, stb_d;
  logic                err_q, err_d;
  logic [7:0]          addr_q, addr_d;
  logic [31:0]         data_q, data_d;

  // Round-robin search: rotate the valid vector so the rr pointer sits at bit 0.
  logic [2*NUM_REQ-1:0] valid_dbl;
  logic [NUM_REQ-1:0]   valid_rot;
  logic [IdW-1:0]       pick_off;
  logic [IdW:0]         pick_sum;
  logic [IdW-1:0]       pick;
  logic                 pick_found;

  always_comb begin
    valid_dbl  = {req_tvalid, req_tvalid};
    valid_rot  = NUM_REQ'(valid_dbl >> rr_q);
    pick_found = |valid_rot;
    pick_off   = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (valid_rot[i]) pick_off = IdW'(i);
    end
    pick_sum = {1'b0, rr_q} + {1'b0, pick_off};
    if (pick_sum >= (IdW+1)'(NUM_REQ)) pick_sum = pick_sum - (IdW+1)'(NUM_REQ);
    pick = pick_sum[IdW-1:0];
  end

  // Granted requester's beat.
  logic [39:0] sel_beat;
  logic        sel_valid;
  logic        sel_last;

  always_comb begin
    sel_beat  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_q == IdW'(i)) begin
        sel_beat  = req_tdata[i*40 +: 40];
        sel_valid = req_tvalid[i];
        sel_last  = req_tlast[i];
      end
    end
  end

  logic           can_accept;
  logic           hs;
  logic           beat_rate;
  logic           hit_now;
  logic           stall_inc;
  logic [IdW-1:0] rr_next;

  // A pending clear holds WRITE one extra cycle so the flush never overlaps the last strobe.
  assign can_accept = (state_q == StWrite) && !clr_pend_q && (gap_q == 4'd0);
  assign hs         = can_accept && sel_valid;
  assign stall_inc  = can_accept && !sel_valid;
  assign beat_rate  = RATE_ADDR_MAP[sel_beat[39:32]];
  assign hit_now    = rate_hit_q || beat_rate;
  assign rr_next    = (grant_q == IdW'(NUM_REQ - 1)) ? '0 : grant_q + IdW'(1);

  always_comb begin
    req_tready = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      req_tready[i] = can_accept && (grant_q == IdW'(i));
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_d       = rr_q;
    gap_d      = gap_q;
    clr_cnt_d  = clr_cnt_q;
    stall_d    = stall_q;
    rate_hit_d = rate_hit_q;
    clr_pend_d = clr_pend_q;
    stb_d      = 1'b0;
    err_d      = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;

    if (hs) begin
      gap_d = 4'(STB_GAP);
    end else if (gap_q != 4'd0) begin
      gap_d = gap_q - 4'd1;
    end

    unique case (state_q)
      StIdle: begin
        stall_d = '0;
        if (pick_found) begin
          grant_d = pick;
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (clr_pend_q) begin
          clr_pend_d = 1'b0;
          clr_cnt_d  = 8'(CLEAR_CYCLES - 1);
          state_d    = StClear;
        end else if (hs) begin
          stb_d      = 1'b1;
          addr_d     = sel_beat[39:32];
          data_d     = sel_beat[31:0];
          stall_d    = '0;
          rate_hit_d = hit_now;
          if (sel_last) begin
            rr_d       = rr_next;
            rate_hit_d = 1'b0;
            if (hit_now) clr_pend_d = 1'b1;
            else         state_d    = StIdle;
          end
        end else if (stall_inc) begin
          stall_d = stall_q + StallW'(1);
          if (stall_q == StallW'(TIMEOUT - 1)) begin
            err_d      = 1'b1;
            stall_d    = '0;
            rr_d       = rr_next;
            rate_hit_d = 1'b0;
            if (rate_hit_q) begin
              clr_cnt_d = 8'(CLEAR_CYCLES - 1);
              state_d   = StClear;
            end else begin
              state_d   = StIdle;
            end
          end
        end
      end
      StClear: begin
        if (clr_cnt_q == 8'd0) state_d = StIdle;
        else                   clr_cnt_d = clr_cnt_q - 8'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      rr_q       <= '0;
      gap_q      <= '0;
      clr_cnt_q  <= '0;
      stall_q    <= '0;
      rate_hit_q <= 1'b0;
      clr_pend_q <= 1'b0;
      stb_q      <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      gap_q      <= gap_d;
      clr_cnt_q  <= clr_cnt_d;
      stall_q    <= stall_d;
      rate_hit_q <= rate_hit_d;
      clr_pend_q <= clr_pend_d;
      stb_q      <= stb_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  assign set_stb     = stb_q;
  assign set_addr    = addr_q;
  assign set_data    = data_q;
  assign clear_user  = (state_q == StClear);
  assign busy        = (state_q != StIdle);
  assign grant_id    = grant_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_ducddc_setting_sched.sv
// Directed bench for ducddc_setting_sched: burst ordering, strobe spacing, clear pulse,
// stall timeout, asynchronous reset and the zero-gap streaming case.
module tb_ducddc_setting_sched;

  localparam int NR = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance (default parameters, STB_GAP=1).
  logic [39:0]      td [NR];
  logic [NR-1:0]    tl;
  logic [NR-1:0]    tv;
  logic [NR*40-1:0] req_tdata;
  logic [NR-1:0]    req_tready;
  logic             set_stb;
  logic [7:0]       set_addr;
  logic [31:0]      set_data;
  logic             clear_user;
  logic             busy;
  logic [1:0]       grant_id;
  logic             err_timeout;

  assign req_tdata = {td[2], td[1], td[0]};

  ducddc_setting_sched dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_tdata  (req_tdata),
    .req_tlast  (tl),
    .req_tvalid (tv),
    .req_tready (req_tready),
    .set_stb    (set_stb),
    .set_addr   (set_addr),
    .set_data   (set_data),
    .clear_user (clear_user),
    .busy       (busy),
    .grant_id   (grant_id),
    .err_timeout(err_timeout)
  );

  // Second instance with STB_GAP=0.
  logic [NR*40-1:0] td0;
  logic [NR-1:0]    tl0;
  logic [NR-1:0]    tv0;
  logic [NR-1:0]    req_tready0;
  logic             set_stb0;
  logic [7:0]       set_addr0;
  logic [31:0]      set_data0;
  logic             clear_user0;
  logic             busy0;
  logic [1:0]       grant_id0;
  logic             err_timeout0;

  ducddc_setting_sched #(.STB_GAP(0)) dut0 (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_tdata  (td0),
    .req_tlast  (tl0),
    .req_tvalid (tv0),
    .req_tready (req_tready0),
    .set_stb    (set_stb0),
    .set_addr   (set_addr0),
    .set_data   (set_data0),
    .clear_user (clear_user0),
    .busy       (busy0),
    .grant_id   (grant_id0),
    .err_timeout(err_timeout0)
  );

  // Passive log of strobes, clear runs and error-pulse cycles.
  typedef struct {
    int          c;
    logic [7:0]  a;
    logic [31:0] d;
    int          g;
  } stb_t;

  int   cyc = 0;
  stb_t log_q[$];
  int   clr_runs = 0;
  int   clr_len = 0;
  int   clr_start = 0;
  int   err_cycles = 0;
  logic clr_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (set_stb) log_q.push_back('{cyc, set_addr, set_data, int'(grant_id)});
    if (clear_user) begin
      if (!clr_prev) begin
        clr_runs++;
        clr_start = cyc;
        clr_len = 0;
      end
      clr_len++;
    end
    clr_prev = clear_user;
    if (err_timeout) err_cycles++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one beat, wait (bounded) for the handshake edge, then drop valid.
  task automatic send_beat(input int r, input logic [7:0] a, input logic [31:0] d,
                           input logic last);
    int budget = 300;
    td[r] = {a, d};
    tl[r] = last;
    tv[r] = 1'b1;
    while (!req_tready[r] && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    check_eq($sformatf("ready_req%0d_addr%0d", r, a), 64'(req_tready[r]), 64'd1);
    @(posedge clk);
    #1;
    tv[r] = 1'b0;
    tl[r] = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int budget = 200;
    while (busy && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    check_eq(tag, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b, r0, e0;
    for (int i = 0; i < NR; i++) td[i] = '0;
    tl = '0; tv = '0; td0 = '0; tl0 = '0; tv0 = '0;

    // Reset values
    tick(3);
    check_eq("rst_stb", 64'(set_stb), 64'd0);
    check_eq("rst_clear", 64'(clear_user), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_tready", 64'(req_tready), 64'd0);
    check_eq("rst_grant", 64'(grant_id), 64'd0);
    check_eq("rst_err", 64'(err_timeout), 64'd0);
    check_eq("rst_addr", 64'(set_addr), 64'd0);
    check_eq("rst_data", 64'(set_data), 64'd0);
    reset_n = 1'b1;
    tick(2);

    // T1: two-beat non-rate burst, STB_GAP=1 -> strobes two cycles apart, no clear
    b = log_q.size(); r0 = clr_runs;
    send_beat(0, 8'd141, 32'h1000, 1'b0);
    send_beat(0, 8'd142, 32'h2000, 1'b1);
    tick(3);
    check_eq("t1_count", 64'(log_q.size() - b), 64'd2);
    check_eq("t1_addr0", 64'(log_q[b].a), 64'd141);
    check_eq("t1_data0", 64'(log_q[b].d), 64'h1000);
    check_eq("t1_addr1", 64'(log_q[b+1].a), 64'd142);
    check_eq("t1_data1", 64'(log_q[b+1].d), 64'h2000);
    check_eq("t1_spacing", 64'(log_q[b+1].c - log_q[b].c), 64'd2);
    check_eq("t1_no_clear", 64'(clr_runs - r0), 64'd0);
    check_eq("t1_busy", 64'(busy), 64'd0);

    // T2: single rate beat from req1 -> one strobe then 4-cycle clear after it
    b = log_q.size(); r0 = clr_runs;
    send_beat(1, 8'd143, 32'd4, 1'b1);
    wait_idle("t2_idle");
    check_eq("t2_count", 64'(log_q.size() - b), 64'd1);
    check_eq("t2_addr", 64'(log_q[b].a), 64'd143);
    check_eq("t2_data", 64'(log_q[b].d), 64'd4);
    check_eq("t2_grant", 64'(log_q[b].g), 64'd1);
    check_eq("t2_clear_runs", 64'(clr_runs - r0), 64'd1);
    check_eq("t2_clear_len", 64'(clr_len), 64'd4);
    check_eq("t2_clear_after_stb", 64'(clr_start > log_q[b].c), 64'd1);

    // T3: three simultaneous 2-beat bursts from rr=0, twice
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(1);
    for (int rep = 0; rep < 2; rep++) begin
      b = log_q.size();
      fork
        begin
          send_beat(0, 8'h10, 32'hD000_0010, 1'b0);
          send_beat(0, 8'h11, 32'hD000_0011, 1'b1);
        end
        begin
          send_beat(1, 8'h20, 32'hD000_0020, 1'b0);
          send_beat(1, 8'h21, 32'hD000_0021, 1'b1);
        end
        begin
          send_beat(2, 8'h30, 32'hD000_0030, 1'b0);
          send_beat(2, 8'h31, 32'hD000_0031, 1'b1);
        end
      join
      wait_idle("t3_idle");
      tick(2);
      check_eq($sformatf("t3_rep%0d_count", rep), 64'(log_q.size() - b), 64'd6);
      for (int k = 0; k < 6; k++) begin
        logic [7:0] ea;
        ea = 8'((k / 2 + 1) * 16 + k % 2);
        check_eq($sformatf("t3_rep%0d_grant%0d", rep, k), 64'(log_q[b+k].g), 64'(k / 2));
        check_eq($sformatf("t3_rep%0d_addr%0d", rep, k), 64'(log_q[b+k].a), 64'(ea));
        check_eq($sformatf("t3_rep%0d_data%0d", rep, k), 64'(log_q[b+k].d),
                 64'(32'hD000_0000 | 32'(ea)));
      end
    end

    // T4: req2 stalls after a rate beat -> timeout, clear, then req0 is served
    b = log_q.size(); r0 = clr_runs; e0 = err_cycles;
    send_beat(2, 8'd129, 32'h55, 1'b0);
    send_beat(0, 8'h05, 32'h77, 1'b1);
    wait_idle("t4_idle");
    tick(2);
    check_eq("t4_err_cycles", 64'(err_cycles - e0), 64'd1);
    check_eq("t4_clear_runs", 64'(clr_runs - r0), 64'd1);
    check_eq("t4_clear_len", 64'(clr_len), 64'd4);
    check_eq("t4_count", 64'(log_q.size() - b), 64'd2);
    check_eq("t4_addr0", 64'(log_q[b].a), 64'd129);
    check_eq("t4_grant0", 64'(log_q[b].g), 64'd2);
    check_eq("t4_timeout_delay", 64'(clr_start - log_q[b].c), 64'd65);
    check_eq("t4_addr1", 64'(log_q[b+1].a), 64'h05);
    check_eq("t4_grant1", 64'(log_q[b+1].g), 64'd0);
    check_eq("t4_served_after_clear", 64'(log_q[b+1].c > clr_start + 3), 64'd1);

    // T5a: reset while clearing
    send_beat(1, 8'd143, 32'd9, 1'b1);
    begin
      int budget = 20;
      while (!clear_user && budget > 0) begin
        @(posedge clk);
        #1;
        budget--;
      end
    end
    check_eq("t5a_in_clear", 64'(clear_user), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t5a_stb", 64'(set_stb), 64'd0);
    check_eq("t5a_clear", 64'(clear_user), 64'd0);
    check_eq("t5a_busy", 64'(busy), 64'd0);
    check_eq("t5a_tready", 64'(req_tready), 64'd0);
    tick(1);
    reset_n = 1'b1;
    tick(1);

    // T5b: reset during a WRITE stall
    send_beat(0, 8'h07, 32'd1, 1'b0);
    tick(3);
    check_eq("t5b_stalling", 64'(req_tready), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t5b_stb", 64'(set_stb), 64'd0);
    check_eq("t5b_clear", 64'(clear_user), 64'd0);
    check_eq("t5b_busy", 64'(busy), 64'd0);
    check_eq("t5b_tready", 64'(req_tready), 64'd0);
    tick(1);
    reset_n = 1'b1;
    tick(1);
    b = log_q.size();
    fork
      send_beat(1, 8'h08, 32'd8, 1'b1);
      send_beat(0, 8'h09, 32'd9, 1'b1);
    join
    wait_idle("t5_idle");
    tick(2);
    check_eq("t5_first_grant", 64'(log_q[b].g), 64'd0);
    check_eq("t5_first_addr", 64'(log_q[b].a), 64'h09);
    check_eq("t5_second_grant", 64'(log_q[b+1].g), 64'd1);

    // T6: STB_GAP=0 streaming, four beats with valid held high
    tv0[0] = 1'b1;
    td0[39:0] = {8'h40, 32'hB0};
    begin
      int budget = 20;
      while (!req_tready0[0] && budget > 0) begin
        @(posedge clk);
        #1;
        budget--;
      end
    end
    for (int i = 0; i < 4; i++) begin
      td0[39:0] = {8'(8'h40 + i), 32'(32'hB0 + i)};
      tl0[0] = (i == 3);
      check_eq($sformatf("t6_ready%0d", i), 64'(req_tready0[0]), 64'd1);
      @(posedge clk);
      #1;
      check_eq($sformatf("t6_stb%0d", i), 64'(set_stb0), 64'd1);
      check_eq($sformatf("t6_addr%0d", i), 64'(set_addr0), 64'(8'h40 + i));
      check_eq($sformatf("t6_data%0d", i), 64'(set_data0), 64'(32'hB0 + i));
    end
    tv0 = '0;
    tl0 = '0;
    tick(1);
    check_eq("t6_stb_end", 64'(set_stb0), 64'd0);
    check_eq("t6_busy", 64'(busy0), 64'd0);
    check_eq("t6_no_clear", 64'(clear_user0), 64'd0);
    check_eq("t6_no_err", 64'(err_timeout0), 64'd0);
    check_eq("t6_grant", 64'(grant_id0), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
